// File: rtl/systolic_ctrl_pkg.sv
// rtl/systolic_ctrl_pkg.sv - shared types and constants for the systolic array edge controllers
package systolic_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_INIT  = 3'd2,
        ST_SKEW  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } wf_state_t;

    localparam int DEFAULT_ROWS          = 4;
    localparam int DEFAULT_COLS          = 4;
    localparam int DEFAULT_K_W           = 8;
    localparam int DEFAULT_DRAIN_TIMEOUT = 255;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wavefront_skew_line.sv
// rtl/wavefront_skew_line.sv - per-row register skew of a 2-bit {in_valid, init} base wavefront
module wavefront_skew_line #(
    parameter int ROWS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      base,
    output logic [ROWS-1:0] valid_row,
    output logic [ROWS-1:0] init_row
);

    // tap[r] is the base delayed r cycles; row 0 passes straight through.
    logic [1:0] tap [ROWS];

    assign tap[0] = base;

    for (genvar r = 1; r < ROWS; r++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                tap[r] <= 2'b00;
            end else begin
                tap[r] <= tap[r-1];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign valid_row[r] = tap[r][1];
        assign init_row[r]  = tap[r][0];
    end

endmodule

// File: rtl/pe_wavefront_ctrl.sv
// rtl/pe_wavefront_ctrl.sv - column-0 in_valid/init source and east-edge drain tracker for the PE array
module pe_wavefront_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int COLS          = DEFAULT_COLS,
    parameter int K_W           = DEFAULT_K_W,
    parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    input  logic [ROWS-1:0] drain_valid,
    output logic [ROWS-1:0] in_valid_row,
    output logic [ROWS-1:0] init_row,
    output logic            busy,
    output logic            done,
    output logic            err_timeout,
    output logic            err_overflow,
    output logic            err_spurious
);

    localparam int CNT_W = count_width(COLS);
    localparam int DRN_W = count_width(DRAIN_TIMEOUT);
    localparam int SKW_W = count_width(ROWS);

    localparam logic [CNT_W-1:0] COLS_FULL  = CNT_W'(COLS);
    localparam logic [CNT_W-1:0] COLS_LAST  = CNT_W'(COLS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [SKW_W-1:0] SKEW_LOAD  = SKW_W'(ROWS - 1);

    wf_state_t        state;
    wf_state_t        state_nx;
    logic [K_W-1:0]   k_cnt;
    logic [SKW_W-1:0] skew_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [CNT_W-1:0] row_cnt [ROWS];

    logic accept;
    logic counting;
    logic all_done;
    logic drain_expired;

    assign accept        = (state == ST_IDLE) && start && (k_len != '0);
    assign counting      = (state == ST_INIT) || (state == ST_SKEW) || (state == ST_DRAIN);
    assign drain_expired = (drain_cnt == DRAIN_LAST);

    // A row is finished if already full, or one short with a beat arriving now.
    always_comb begin
        all_done = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            if (!((row_cnt[r] == COLS_FULL) ||
                  ((row_cnt[r] == COLS_LAST) && drain_valid[r]))) begin
                all_done = 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (accept) state_nx = ST_FEED;
            ST_FEED:  if (k_cnt == K_W'(1)) state_nx = ST_INIT;
            ST_INIT:  state_nx = (ROWS == 1) ? ST_DRAIN : ST_SKEW;
            ST_SKEW:  if (skew_cnt == SKW_W'(1)) state_nx = ST_DRAIN;
            ST_DRAIN: if (all_done || drain_expired) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            k_cnt        <= '0;
            skew_cnt     <= '0;
            drain_cnt    <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
            err_spurious <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                row_cnt[r] <= '0;
            end
        end else begin
            state <= state_nx;

            if (accept) begin
                k_cnt        <= k_len;
                drain_cnt    <= '0;
                err_timeout  <= 1'b0;
                err_overflow <= 1'b0;
                err_spurious <= 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    row_cnt[r] <= '0;
                end
            end else if (state == ST_FEED) begin
                k_cnt <= k_cnt - K_W'(1);
            end

            if (state == ST_INIT) begin
                skew_cnt <= SKEW_LOAD;
            end else if (state == ST_SKEW) begin
                skew_cnt <= skew_cnt - SKW_W'(1);
            end

            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + DRN_W'(1);
                if (!all_done && drain_expired) begin
                    err_timeout <= 1'b1;
                end
            end

            if (counting) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (drain_valid[r]) begin
                        if (row_cnt[r] == COLS_FULL) begin
                            err_overflow <= 1'b1;
                        end else begin
                            row_cnt[r] <= row_cnt[r] + CNT_W'(1);
                        end
                    end
                end
            end

            // Set after the accept clear so a beat on the accepting cycle is still flagged.
            if (((state == ST_IDLE) || (state == ST_FEED)) && (drain_valid != '0)) begin
                err_spurious <= 1'b1;
            end
        end
    end

    wavefront_skew_line #(
        .ROWS (ROWS)
    ) u_skew (
        .clk       (clk),
        .rst       (rst),
        .base      ({state == ST_FEED, state == ST_INIT}),
        .valid_row (in_valid_row),
        .init_row  (init_row)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: doc/pe_wavefront_ctrl.md
# pe_wavefront_ctrl

Array-edge control source for the output-stationary systolic array. It drives the column-0 `in_valid`/`init` inputs of every PE row, with one cycle of skew per row. It then tracks per-row drain beats arriving at the east edge and signals completion. This block is the initiator of the PE control protocol: a `K`-beat `in_valid` burst, followed by a 1-cycle `init` pulse that switches PEs into drain.

## Interface
- ROWS, 4, array rows (≥1)
- COLS, 4, array columns; drain beats expected per row
- K_W, 8, width of reduction length
- DRAIN_TIMEOUT, 255, max cycles in DRAIN before abort (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a tile pass; sampled in IDLE only
- k_len  in  K_W  reduction length K, sampled with start
- drain_valid  in  ROWS  east-edge out_valid per row
- in_valid_row  out  ROWS  column-0 in_valid per row (also operand-buffer read strobe)
- init_row  out  ROWS  column-0 init pulse per row
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle completion pulse
- err_timeout  out  1  sticky: drain aborted on timeout
- err_overflow  out  1  sticky: more than COLS beats seen on some row
- err_spurious  out  1  sticky: drain beat seen in IDLE or FEED

## Operation
- FSM states: IDLE, FEED, INIT, SKEW, DRAIN, DONE.
- IDLE → FEED when start=1 and k_len≠0. This is the accepted start.
  - Loads the K counter.
  - Clears the row counters, drain-cycle counter and all err flags.
- start with k_len=0, or any start outside IDLE: ignored, no flag.
- FEED lasts exactly K cycles, then → INIT.
- INIT lasts 1 cycle, then → SKEW, or → DRAIN if ROWS=1.
- SKEW lasts ROWS−1 cycles, then → DRAIN.
- DRAIN → DONE when every row count reaches COLS.
  - Completion is evaluated on the registered counts plus the current cycle's drain_valid.
  - Also → DONE when the drain-cycle counter reaches DRAIN_TIMEOUT; this sets err_timeout.
- DONE lasts 1 cycle, then → IDLE.
- Base wavefront signals:
  - in_valid_row[0] = (state==FEED).
  - init_row[0] = (state==INIT).
  - Row r is row 0 delayed r cycles through a register delay line.
- Row counters: one per row, width clog2(COLS+1).
  - Increment on drain_valid[r] in INIT, SKEW or DRAIN. Early rows finish draining while later rows are still skewing.
  - Saturate at COLS; a beat at COLS sets err_overflow.
- drain_valid in IDLE or FEED: not counted; sets err_spurious.
- Err flags hold until the next accepted start or rst.
- Reset (including mid-operation):
  - state=IDLE.
  - Delay line, counters and all outputs = 0 in the cycle after the rst edge.

## Timing
- Accepted start sampled at edge E0; t0 is the cycle after E0.
- in_valid_row[r] is high during t0+r … t0+r+K−1.
- init_row[r] is high during t0+K+r only; it always immediately follows the last valid beat.
- Last init is at t0+K+ROWS−1; DRAIN starts at t0+K+ROWS.
- done is high in the cycle after the cycle carrying the final required beat.
- Timeout: done at DRAIN entry + DRAIN_TIMEOUT cycles.
- A new start is accepted in IDLE, earliest the cycle after done. Back-to-back pass period is therefore K+ROWS+drain+2 cycles minimum.
- No combinational path from any input to any output.

## Structure
- Shared package systolic_ctrl_pkg holds:
  - FSM state enum (3-bit encoding).
  - clog2-based width localparams.
  - Default DRAIN_TIMEOUT constant.
- Sub-module wavefront_skew_line: ROWS-deep shift register fanning a 2-bit {in_valid, init} base into per-row outputs. It is reused by the operand-feed path.

## Test plan
- ROWS=4, K=3, start sampled at cycle 0:
  - in_valid_row[0] high cycles 1–3; init_row[0] at 4.
  - in_valid_row[3] high 4–6; init_row[3] at 7.
  - busy high from 1; DRAIN at 8.
- Same pass, model drives 4 beats per row, row 3's last beat at cycle 20 → done high at cycle 21 only, busy 0 at 22, all err=0.
- No drain beats, DRAIN_TIMEOUT=255 → done at DRAIN entry+255, err_timeout=1, cleared by the next start.
- 5 beats on row 1 → err_overflow=1, done still on completion.
- drain_valid in IDLE → err_spurious=1.
- start with k_len=0 → busy stays 0.
- start pulsed during FEED → no effect on schedule.
- rst asserted at cycle 2 of FEED (K=8) → next cycle: all outputs 0, IDLE.
- Fresh start after reset → schedule as in the first scenario.
